// File: rtl/vmask_pkg.sv
// vmask_pkg: shared modes, width helper and not-found constant for vmask_reduce
package vmask_pkg;
  localparam logic MODE_POPC = 1'b0;
  localparam logic MODE_FIRST = 1'b1;
  localparam logic [255:0] NOT_FOUND = '1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/vmask_chunk_stat.sv
// vmask_chunk_stat: popcount, lowest-set-bit index and nonzero flag of one beat
module vmask_chunk_stat
  import vmask_pkg::*;
#(
  parameter int REQ_DATA_WIDTH = 64,
  localparam int IW = clog2(REQ_DATA_WIDTH),
  localparam int PW = IW + 1
) (
  input  logic [REQ_DATA_WIDTH-1:0] e_i,
  output logic [PW-1:0]             pc_o,
  output logic [IW-1:0]             ff_o,
  output logic                      nz_o
);
  // Level l of the adder tree holds REQ_DATA_WIDTH>>l partial sums.
  for (genvar l = 0; l <= IW; l++) begin : g_lvl
    logic [PW-1:0] s [REQ_DATA_WIDTH>>l];
    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < REQ_DATA_WIDTH; k++) begin : g_k
        assign s[k] = PW'(e_i[k]);
      end
    end else begin : g_add
      for (genvar k = 0; k < (REQ_DATA_WIDTH >> l); k++) begin : g_k
        assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
      end
    end
  end
  assign pc_o = g_lvl[IW].s[0];
  assign nz_o = |e_i;
  always_comb begin
    ff_o = '0;
    for (int i = REQ_DATA_WIDTH - 1; i >= 0; i--) if (e_i[i]) ff_o = IW'(i);
  end
endmodule

// File: rtl/vmask_reduce.sv
// vmask_reduce: streaming vcpop.m / vfirst.m reduction over masked beats.
// S1 input register, S2 beat statistics, S3 accumulators, then an output register.
module vmask_reduce
  import vmask_pkg::*;
#(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_end,
  input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
  input  logic [REQ_DATA_WIDTH-1:0]  in_vmask,
  input  logic                       in_mode,
  input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
  output logic [RESP_DATA_WIDTH-1:0] out_vec,
  output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
  output logic                       out_valid
);
  localparam int IW = clog2(REQ_DATA_WIDTH);
  localparam int PW = IW + 1;
  localparam logic [RESP_DATA_WIDTH-1:0] NF = NOT_FOUND[RESP_DATA_WIDTH-1:0];
  logic                       s1_v_q, s1_end_q, s1_mode_q;
  logic [REQ_DATA_WIDTH-1:0]  s1_e_q;
  logic [REQ_ADDR_WIDTH-1:0]  s1_addr_q;
  logic [PW-1:0]              pc;
  logic [IW-1:0]              ff;
  logic                       nz;
  logic                       s2_v_q, s2_end_q, s2_mode_q, s2_nz_q;
  logic [PW-1:0]              s2_pc_q;
  logic [IW-1:0]              s2_ff_q;
  logic [REQ_ADDR_WIDTH-1:0]  s2_addr_q;
  logic [RESP_DATA_WIDTH-1:0] count_q, count_d, base_q, base_d, first_q, first_d;
  logic                       found_q, found_d;
  logic [RESP_DATA_WIDTH-1:0] cnt_n, fst_n, res_vec_q, res_vec_d, out_vec_q;
  logic [REQ_ADDR_WIDTH-1:0]  res_addr_q, res_addr_d, out_addr_q;
  logic                       fnd_n, fin, res_v_q, res_v_d, out_v_q;
  vmask_chunk_stat #(.REQ_DATA_WIDTH(REQ_DATA_WIDTH)) u_stat (
    .e_i (s1_e_q),
    .pc_o(pc),
    .ff_o(ff),
    .nz_o(nz)
  );
  always_comb begin
    cnt_n      = count_q + RESP_DATA_WIDTH'(s2_pc_q);
    fnd_n      = found_q | s2_nz_q;
    fst_n      = (!found_q && s2_nz_q) ? base_q + RESP_DATA_WIDTH'(s2_ff_q) : first_q;
    fin        = s2_v_q && s2_end_q;
    count_d    = !s2_v_q ? count_q : fin ? '0 : cnt_n;
    base_d     = !s2_v_q ? base_q : fin ? '0 : base_q + RESP_DATA_WIDTH'(REQ_DATA_WIDTH);
    found_d    = !s2_v_q ? found_q : fin ? 1'b0 : fnd_n;
    first_d    = !s2_v_q ? first_q : fin ? '0 : fst_n;
    res_v_d    = fin;
    res_vec_d  = !fin ? '0 : (s2_mode_q == MODE_FIRST) ? (fnd_n ? fst_n : NF) : cnt_n;
    res_addr_d = fin ? s2_addr_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_v_q, s1_end_q, s1_mode_q, s1_e_q, s1_addr_q} <= '0;
      {s2_v_q, s2_end_q, s2_mode_q, s2_nz_q, s2_pc_q, s2_ff_q, s2_addr_q} <= '0;
      {count_q, base_q, first_q, found_q} <= '0;
      {res_v_q, res_vec_q, res_addr_q, out_v_q, out_vec_q, out_addr_q} <= '0;
    end else begin
      s1_v_q     <= in_valid;
      s1_end_q   <= in_valid & in_end;
      s1_mode_q  <= in_mode;
      s1_e_q     <= in_m0 & in_vmask;
      s1_addr_q  <= in_addr;
      s2_v_q     <= s1_v_q;
      s2_end_q   <= s1_end_q;
      s2_mode_q  <= s1_mode_q;
      s2_addr_q  <= s1_addr_q;
      s2_pc_q    <= pc;
      s2_ff_q    <= ff;
      s2_nz_q    <= nz;
      count_q    <= count_d;
      base_q     <= base_d;
      found_q    <= found_d;
      first_q    <= first_d;
      res_v_q    <= res_v_d;
      res_vec_q  <= res_vec_d;
      res_addr_q <= res_addr_d;
      out_v_q    <= res_v_q;
      out_vec_q  <= res_vec_q;
      out_addr_q <= res_addr_q;
    end
  end
  assign out_valid = out_v_q;
  assign out_vec   = out_vec_q;
  assign out_addr  = out_addr_q;
endmodule

// File: tb/tb_vmask_reduce.sv
// tb_vmask_reduce: directed table and sequence checks for vmask_reduce
module tb_vmask_reduce;
  import vmask_pkg::*;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_end = 0, in_mode = 0;
  logic [63:0] in_m0 = '0, in_vmask = '0;
  logic [31:0] in_addr = '0;
  logic [63:0] out_vec;
  logic [31:0] out_addr;
  logic        out_valid;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int c; logic [63:0] v; logic [31:0] a;} ev_t;
  ev_t q[$];
  typedef struct {logic [63:0] m0, vm; logic md; logic [31:0] a; logic [63:0] exp;} vec_t;
  vec_t tbl[9];
  localparam logic [63:0] ONES = '1;

  vmask_reduce #(.REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64), .REQ_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_end(in_end), .in_m0(in_m0),
    .in_vmask(in_vmask), .in_mode(in_mode), .in_addr(in_addr),
    .out_vec(out_vec), .out_addr(out_addr), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (out_valid) q.push_back('{cyc, out_vec, out_addr});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic e, input logic [63:0] m0, input logic [63:0] vm,
                      input logic md, input logic [31:0] a, output int t);
    @(negedge clk);
    in_valid = v; in_end = e; in_m0 = m0; in_vmask = vm; in_mode = md; in_addr = a;
    @(posedge clk);
    #1 t = cyc;
  endtask

  task automatic idle(input int n);
    int t;
    for (int i = 0; i < n; i++) beat(1'b0, 1'b1, ONES, ONES, MODE_POPC, 32'hdead, t);
  endtask

  task automatic expect_n(input string nm, input int n);
    chk({nm, " count"}, 64'(q.size()), 64'(n));
  endtask

  task automatic expect_e(input string nm, input int i, input logic [63:0] v, input logic [31:0] a, input int c);
    if (i < q.size()) begin
      chk({nm, " vec"}, q[i].v, v);
      chk({nm, " addr"}, 64'(q[i].a), 64'(a));
      chk({nm, " cycle"}, 64'(q[i].c), 64'(c));
    end else begin
      checks++; errors++;
      $display("FAIL %s: result %0d missing, want vec %0h", nm, i, v);
    end
  endtask

  initial begin
    int t, t1;
    tbl[0] = '{64'hFF, ONES, MODE_POPC, 32'h100, 64'd8};
    tbl[1] = '{64'hFFFF, 64'h00F0, MODE_POPC, 32'h104, 64'd4};
    tbl[2] = '{64'hFFFF, 64'h00F0, MODE_FIRST, 32'h108, 64'd4};
    tbl[3] = '{64'h0, ONES, MODE_FIRST, 32'h10C, ONES};
    tbl[4] = '{ONES, ONES, MODE_POPC, 32'h110, 64'd64};
    tbl[5] = '{64'h8000_0000_0000_0000, ONES, MODE_FIRST, 32'h114, 64'd63};
    tbl[6] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, MODE_FIRST, 32'h118, 64'd63};
    tbl[7] = '{64'hA5, ONES, MODE_POPC, 32'h11C, 64'd4};
    tbl[8] = '{ONES, ONES, MODE_FIRST, 32'h120, 64'd0};
    idle(3);
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_vec", out_vec, 64'd0);
    chk("reset out_addr", 64'(out_addr), 64'd0);
    rst = 0;
    idle(2);
    q.delete();
    foreach (tbl[i]) begin
      beat(1'b1, 1'b1, tbl[i].m0, tbl[i].vm, tbl[i].md, tbl[i].a, t);
      idle(6);
      expect_n($sformatf("tbl%0d", i), 1);
      expect_e($sformatf("tbl%0d", i), 0, tbl[i].exp, tbl[i].a, t + 3);
      q.delete();
    end
    // FIRST over three beats with gaps; idle cycles carry a stray in_end
    beat(1'b1, 1'b0, 64'h0, ONES, MODE_POPC, 32'h0, t);
    idle(1);
    beat(1'b1, 1'b0, 64'h0, ONES, MODE_POPC, 32'h0, t);
    idle(1);
    beat(1'b1, 1'b1, 64'h10, ONES, MODE_FIRST, 32'h20, t);
    idle(6);
    expect_n("first3", 1);
    expect_e("first3", 0, 64'd132, 32'h20, t + 3);
    q.delete();
    // first hit in beat 1 must not be overwritten by a later beat
    beat(1'b1, 1'b0, 64'h0, ONES, MODE_POPC, 32'h0, t);
    beat(1'b1, 1'b0, 64'h8, ONES, MODE_POPC, 32'h0, t);
    beat(1'b1, 1'b1, 64'h1, ONES, MODE_FIRST, 32'h24, t);
    idle(6);
    expect_n("firstkeep", 1);
    expect_e("firstkeep", 0, 64'd67, 32'h24, t + 3);
    q.delete();
    beat(1'b1, 1'b0, ONES, ONES, MODE_FIRST, 32'h0, t);
    beat(1'b1, 1'b0, ONES, ONES, MODE_FIRST, 32'h0, t);
    beat(1'b1, 1'b1, ONES, ONES, MODE_POPC, 32'h28, t);
    idle(6);
    expect_n("popc3", 1);
    expect_e("popc3", 0, 64'd192, 32'h28, t + 3);
    q.delete();
    beat(1'b1, 1'b0, 64'hFF, 64'h0, MODE_POPC, 32'h0, t);
    beat(1'b1, 1'b1, 64'hFF, 64'h0, MODE_FIRST, 32'h2C, t);
    idle(6);
    expect_n("nofirst", 1);
    expect_e("nofirst", 0, ONES, 32'h2C, t + 3);
    q.delete();
    beat(1'b1, 1'b1, 64'h3, ONES, MODE_POPC, 32'h1, t1);
    beat(1'b1, 1'b1, 64'h7, ONES, MODE_POPC, 32'h2, t);
    idle(6);
    expect_n("b2b", 2);
    expect_e("b2b0", 0, 64'd2, 32'h1, t1 + 3);
    expect_e("b2b1", 1, 64'd3, 32'h2, t1 + 4);
    q.delete();
    // reset mid-vector, with a valid end beat presented during reset
    beat(1'b1, 1'b0, 64'hF, ONES, MODE_POPC, 32'h0, t);
    beat(1'b1, 1'b0, 64'hF, ONES, MODE_POPC, 32'h0, t);
    @(negedge clk);
    rst = 1; in_valid = 1; in_end = 1; in_m0 = 64'hFF; in_vmask = ONES; in_mode = MODE_POPC; in_addr = 32'h77;
    @(posedge clk);
    @(negedge clk);
    rst = 0; in_valid = 0; in_end = 0;
    beat(1'b1, 1'b1, 64'h1, ONES, MODE_POPC, 32'h55, t);
    idle(6);
    expect_n("rstmid", 1);
    expect_e("rstmid", 0, 64'd1, 32'h55, t + 3);
    q.delete();
    @(negedge clk);
    chk("idle out_vec", out_vec, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
